full_adder_behavioral: RTL and testbench
========================================

FULL_ADDER_BEHAVIORAL -- requirements
Module: full_adder_behavioral

Interface
REQ-001 Parameter CNT_W, default 16: width of the vector counter and the carry counter.
REQ-002 Parameter REG_OUT, default 1: 1 enables the registered outputs; 0 holds Sum_q/Cout_q/q_valid at 0.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port A, input, 1: addend bit.
REQ-006 Port B, input, 1: addend bit.
REQ-007 Port Cin, input, 1: carry-in bit.
REQ-008 Port Sum, output, 1: combinational sum bit.
REQ-009 Port Cout, output, 1: combinational carry-out bit.
REQ-010 Port Sum_q, output, 1: Sum registered one cycle.
REQ-011 Port Cout_q, output, 1: Cout registered one cycle.
REQ-012 Port q_valid, output, 1: Sum_q/Cout_q hold a post-reset sample.
REQ-013 Port cov_map, output, 8: bit {A,B,Cin} is set once that input combination has been sampled.
REQ-014 Port cov_full, output, 1: cov_map == 8'hFF.
REQ-015 Port vec_cnt, output, CNT_W: number of clock edges sampled since reset.
REQ-016 Port carry_cnt, output, CNT_W: number of sampled edges with Cout = 1.

Function
REQ-017 Sum SHALL equal A ^ B ^ Cin and Cout SHALL equal (A&B) | (A&Cin) | (B&Cin), purely combinational, with zero latency.
REQ-018 Sum/Cout SHALL be independent of clk and rst, including when clk is not toggling or rst is undriven or asserted.
REQ-019 The full truth table SHALL hold: 000->S0 C0; 010->1,0; 100->1,0; 110->0,1; 001->1,0; 011->0,1; 101->0,1; 111->1,1 (order A,B,Cin -> Sum,Cout).
REQ-020 With REG_OUT=1, each rising clk edge out of reset SHALL load Sum_q<=Sum and Cout_q<=Cout and set q_valid<=1, giving a latency of exactly 1 cycle.
REQ-021 Each rising edge out of reset SHALL set cov_map[{A,B,Cin}]; bits are sticky until reset.
REQ-022 Each rising edge out of reset SHALL increment vec_cnt by 1, saturating at all-ones with no wrap.
REQ-023 Each rising edge with Cout=1 SHALL increment carry_cnt by 1, saturating at all-ones.
REQ-024 cov_full SHALL be combinational from cov_map.
REQ-025 Input changes between clock edges SHALL affect only Sum/Cout; registered state samples the values present at the edge.

Reset
REQ-026 While rst=1: Sum_q=0, Cout_q=0, q_valid=0, cov_map=0, vec_cnt=0, carry_cnt=0, asserted asynchronously without waiting for clk.
REQ-027 On rst deassertion, the first rising edge performs a normal sample.
REQ-028 Reset mid-operation SHALL clear all state immediately; Sum/Cout continue to track inputs throughout.

Structure
REQ-029 Package fa_pkg SHALL hold the CNT_W default, the coverage-map width constant (8), and the index function {A,B,Cin} -> 0..7.
REQ-030 The combinational adder SHALL be a sub-module full_adder_cell (A, B, Cin -> Sum, Cout), instantiated once; the registers, coverage and counters live in the top level.

Verification
REQ-031 Unclocked sweep: with clk/rst idle, apply all 8 combinations at 10-time-unit spacing -> Sum/Cout match REQ-019 at each step.
REQ-032 Clocked sweep: after reset, apply all 8 combinations over 8 edges -> Sum_q/Cout_q equal the previous cycle's combinational values, cov_full=1, vec_cnt=8, carry_cnt=4.
REQ-033 Async reset: assert rst between edges with cov_map=8'hFF -> all registered outputs are 0 before the next edge, and Sum/Cout remain correct.
REQ-034 Saturation: with CNT_W=3, hold A=B=Cin=1 for 10 edges -> vec_cnt=7, carry_cnt=7, no wrap.
REQ-035 Glitch between edges: toggle A mid-cycle and restore it before the edge -> Sum changes at once, and Sum_q/cov_map reflect only the values present at the edge.
REQ-036 REG_OUT=0: run the clocked sweep -> Sum_q=Cout_q=q_valid=0, while the counters and cov_map still update.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared constants and helpers for the full-adder block: counter width default,
// coverage-map width and the {A,B,Cin} -> coverage-bit index mapping.
package fa_pkg;

   localparam int CNT_W_DEFAULT = 16;
   localparam int COV_W         = 8;

   typedef logic [2:0] combo_idx_t;

   // A is the most significant bit so the index reads like the truth-table row.
   function automatic combo_idx_t combo_index(input logic a, input logic b, input logic cin);
      return {a, b, cin};
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational one-bit full adder; no clock or reset dependency.
module full_adder_cell (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/full_adder_behavioral.sv
// Full adder with an optional one-cycle registered copy, a sticky input-coverage
// map and saturating sample / carry counters.
module full_adder_behavioral
   import fa_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             Cin,
   output logic             Sum,
   output logic             Cout,
   output logic             Sum_q,
   output logic             Cout_q,
   output logic             q_valid,
   output logic [COV_W-1:0] cov_map,
   output logic             cov_full,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [COV_W-1:0] cov_hit;

   full_adder_cell u_cell (
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .Sum  (Sum),
      .Cout (Cout)
   );

   // q_valid semantics: high once Sum_q/Cout_q hold a sample taken on an edge
   // after reset; it is a pure qualifier, there is no ready/back-pressure.
   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               Sum_q   <= 1'b0;
               Cout_q  <= 1'b0;
               q_valid <= 1'b0;
            end else begin
               Sum_q   <= Sum;
               Cout_q  <= Cout;
               q_valid <= 1'b1;
            end
         end
      end else begin : g_noreg
         assign Sum_q   = 1'b0;
         assign Cout_q  = 1'b0;
         assign q_valid = 1'b0;
      end
   endgenerate

   always_comb begin
      cov_hit = '0;
      cov_hit[combo_index(A, B, Cin)] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cov_map <= '0;
      end else begin
         cov_map <= cov_map | cov_hit;
      end
   end

   assign cov_full = (cov_map == {COV_W{1'b1}});

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt   <= '0;
         carry_cnt <= '0;
      end else begin
         if (vec_cnt != CNT_MAX) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
         end
         if (Cout && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Scoreboard bench: three instances (default, CNT_W=3, REG_OUT=0) share inputs;
// each sampled combination is queued and checked against an arithmetic model.
module tb_full_adder_behavioral;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic rst = 1'b0;
   logic A = 1'b0, B = 1'b0, Cin = 1'b0;

   logic       s0, c0, sq0, cq0, v0, f0;
   logic [7:0] m0;
   logic [15:0] vc0, cc0;

   logic       s1, c1, sq1, cq1, v1, f1;
   logic [7:0] m1;
   logic [2:0] vc1, cc1;

   logic       s2, c2, sq2, cq2, v2, f2;
   logic [7:0] m2;
   logic [15:0] vc2, cc2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0] exp_q[$];
   int         m_edges = 0;
   int         m_carry = 0;
   logic [7:0] m_seen  = '0;

   full_adder_behavioral #(.CNT_W(16), .REG_OUT(1'b1)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sum(s0), .Cout(c0),
      .Sum_q(sq0), .Cout_q(cq0), .q_valid(v0), .cov_map(m0), .cov_full(f0),
      .vec_cnt(vc0), .carry_cnt(cc0)
   );

   full_adder_behavioral #(.CNT_W(3), .REG_OUT(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sum(s1), .Cout(c1),
      .Sum_q(sq1), .Cout_q(cq1), .q_valid(v1), .cov_map(m1), .cov_full(f1),
      .vec_cnt(vc1), .carry_cnt(cc1)
   );

   full_adder_behavioral #(.CNT_W(16), .REG_OUT(1'b0)) dut_nr (
      .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sum(s2), .Cout(c2),
      .Sum_q(sq2), .Cout_q(cq2), .q_valid(v2), .cov_map(m2), .cov_full(f2),
      .vec_cnt(vc2), .carry_cnt(cc2)
   );

   // ---------------- clock ----------------
   always #5 if (clk_en) clk = ~clk;

   // ---------------- reference model helpers ----------------
   function automatic int add_total(input logic [2:0] c);
      return int'(c[2]) + int'(c[1]) + int'(c[0]);
   endfunction

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_comb(input string tag);
      int t;
      t = add_total({A, B, Cin});
      check({tag, " sum"},      {31'd0, s0}, 32'(t % 2));
      check({tag, " cout"},     {31'd0, c0}, 32'(t / 2));
      check({tag, " sum_sat"},  {31'd0, s1}, 32'(t % 2));
      check({tag, " sum_nr"},   {31'd0, s2}, 32'(t % 2));
      check({tag, " cout_nr"},  {31'd0, c2}, 32'(t / 2));
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, " sum_q"},   {31'd0, sq0}, 0);
      check({tag, " cout_q"},  {31'd0, cq0}, 0);
      check({tag, " q_valid"}, {31'd0, v0},  0);
      check({tag, " cov_map"}, {24'd0, m0},  0);
      check({tag, " vec_cnt"}, {16'd0, vc0}, 0);
      check({tag, " carry"},   {16'd0, cc0}, 0);
      check({tag, " sat vec"}, {29'd0, vc1}, 0);
      check({tag, " nr cov"},  {24'd0, m2},  0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [2:0] c);
      @(negedge clk);
      {A, B, Cin} = c;
      exp_q.push_back(c);
      #1 check_comb("drv");
   endtask

   // Mid-cycle asynchronous reset; the model forgets all pending samples.
   task automatic do_reset(input string tag);
      #1 rst = 1'b1;
      #1 check_regs_zero(tag);
      check_comb({tag, " rst"});
      exp_q.delete();
      m_edges = 0;
      m_carry = 0;
      m_seen  = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [2:0] c;
      int t;
      #1;
      if (!rst && exp_q.size() != 0) begin
         c = exp_q.pop_front();
         t = add_total(c);
         m_edges++;
         if (t >= 2) m_carry++;
         m_seen[c] = 1'b1;
         check("q_valid",   {31'd0, v0},  1);
         check("sum_q",     {31'd0, sq0}, 32'(t % 2));
         check("cout_q",    {31'd0, cq0}, 32'(t / 2));
         check("cov_map",   {24'd0, m0},  {24'd0, m_seen});
         check("cov_full",  {31'd0, f0},  {31'd0, (m_seen == 8'hFF)});
         check("vec_cnt",   {16'd0, vc0}, 32'(sat(m_edges, 16)));
         check("carry_cnt", {16'd0, cc0}, 32'(sat(m_carry, 16)));
         check("sat vec",   {29'd0, vc1}, 32'(sat(m_edges, 3)));
         check("sat carry", {29'd0, cc1}, 32'(sat(m_carry, 3)));
         check("sat sum_q", {31'd0, sq1}, 32'(t % 2));
         check("nr sum_q",  {31'd0, sq2}, 0);
         check("nr cout_q", {31'd0, cq2}, 0);
         check("nr valid",  {31'd0, v2},  0);
         check("nr cov",    {24'd0, m2},  {24'd0, m_seen});
         check("nr vec",    {16'd0, vc2}, 32'(sat(m_edges, 16)));
         check("nr carry",  {16'd0, cc2}, 32'(sat(m_carry, 16)));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Unclocked sweep, rst idle low then held high.
      for (int i = 0; i < 8; i++) begin
         {A, B, Cin} = 3'(i);
         #1 check_comb("unclk");
         #9;
      end
      rst = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         {A, B, Cin} = 3'(i);
         #1 check_comb("unclk rst");
         #9;
      end
      check_regs_zero("rst noclk");

      clk_en = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;

      // Clocked sweep: all eight combinations, then absolute totals.
      for (int i = 0; i < 8; i++) drive(3'(i));
      @(posedge clk);
      #2;
      check("sweep cov_full", {31'd0, f0}, 1);
      check("sweep vec_cnt", {16'd0, vc0}, 8);
      check("sweep carry_cnt", {16'd0, cc0}, 4);
      check("sweep nr cov_full", {31'd0, f2}, 1);
      check("sweep cov_map ff", {24'd0, m0}, 32'hFF);
      do_reset("async");

      // Saturation: 10 edges of 1+1+1.
      for (int i = 0; i < 10; i++) drive(3'b111);
      @(posedge clk);
      #2;
      check("sat final vec", {29'd0, vc1}, 7);
      check("sat final carry", {29'd0, cc1}, 7);
      check("wide vec", {16'd0, vc0}, 10);
      do_reset("post sat");

      // Glitch: A pulses high between edges and is restored before the edge.
      @(negedge clk);
      {A, B, Cin} = 3'b000;
      exp_q.push_back(3'b000);
      #2 A = 1'b1;
      #1 check("glitch sum", {31'd0, s0}, 1);
      A = 1'b0;
      #1 check("glitch restore", {31'd0, s0}, 0);
      @(posedge clk);
      #2;
      check("glitch cov", {24'd0, m0}, 32'h01);
      check("glitch sum_q", {31'd0, sq0}, 0);

      // Random traffic with one extra mid-run reset.
      for (int i = 0; i < 120; i++) drive(3'($urandom_range(0, 7)));
      @(posedge clk);
      #2 do_reset("rand");
      for (int i = 0; i < 120; i++) drive(3'($urandom_range(0, 7)));
      @(posedge clk);
      #2;
      check("queue drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
